// File: rtl/bias_loader_pkg.sv
// Shared types and constants for the bias loader.
package bias_loader_pkg;

    localparam int MAX_BIAS_DEFAULT = 10;
    localparam int BYTES_PER_WORD   = 4;
    localparam int BIAS_PER_WORD    = 2;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        WR_LO,
        WR_HI,
        DONE
    } bias_ld_state_t;

endpackage

// File: rtl/bias_loader_if.sv
// Single-outstanding read bus between the bias loader (master) and memory (slave).
interface bias_loader_if #(
    parameter int ADDR_W = 32
);
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_resp_valid;
    logic [31:0]       rd_resp_data;

    modport master (
        output rd_req_valid,
        output rd_req_addr,
        input  rd_req_ready,
        input  rd_resp_valid,
        input  rd_resp_data
    );

    modport slave (
        input  rd_req_valid,
        input  rd_req_addr,
        output rd_req_ready,
        output rd_resp_valid,
        output rd_resp_data
    );
endinterface

// File: rtl/bias_loader.sv
// Loads 16-bit biases (two per bus word, low half first) into local bias memory.
// BIAS_LOADER_RANGE_CHECK_EN: reject count 0 / count > MAX_BIAS with err instead of clamping.
module bias_loader
    import bias_loader_pkg::*;
#(
    parameter int MAX_BIAS = MAX_BIAS_DEFAULT,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       bias_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              bias_ready,
    bias_loader_if.master     bus,
    output logic              write_bias_signal,
    output logic [15:0]       bias_addr,
    output logic [15:0]       write_bias_data
);

    bias_ld_state_t    state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       count_q;
    logic [14:0]       k_q;
    logic [15:0]       hi_q;
    logic [15:0]       baddr_q;
    logic [15:0]       wdata_q;
    logic              busy_q, done_q, err_q, ready_q, req_vld_q, wr_q;

    logic [15:0] cnt_d;
    logic        cnt_bad;
    logic [15:0] lo_idx, hi_idx;
    logic        last_lo, last_hi;

`ifdef BIAS_LOADER_RANGE_CHECK_EN
    assign cnt_d   = bias_count;
    assign cnt_bad = (bias_count == 16'd0) || (32'(bias_count) > 32'(MAX_BIAS));
`else
    assign cnt_d   = (32'(bias_count) > 32'(MAX_BIAS)) ? 16'(MAX_BIAS) : bias_count;
    assign cnt_bad = 1'b0;
`endif

    // Entry indices of the current word; 17-bit compares so count 0xFFFF cannot wrap.
    assign lo_idx  = 16'(k_q) * 16'(BIAS_PER_WORD);
    assign hi_idx  = lo_idx + 16'd1;
    assign last_lo = ({1'b0, lo_idx} + 17'd1) == {1'b0, count_q};
    assign last_hi = ({1'b0, hi_idx} + 17'd1) == {1'b0, count_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            count_q   <= '0;
            k_q       <= '0;
            hi_q      <= '0;
            baddr_q   <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            req_vld_q <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q  <= base_addr;
                        count_q <= cnt_d;
                        k_q     <= '0;
                        err_q   <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (cnt_bad) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (cnt_d == 16'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                        end else begin
                            state_q   <= REQ;
                            req_vld_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // addr_q only moves in WR_HI, so the request stays stable while stalled
                    if (bus.rd_req_ready) begin
                        req_vld_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.rd_resp_valid) begin
                        hi_q    <= bus.rd_resp_data[31:16];
                        wr_q    <= 1'b1;
                        baddr_q <= lo_idx;
                        wdata_q <= bus.rd_resp_data[15:0];
                        state_q <= WR_LO;
                    end
                end
                WR_LO: begin
                    if (last_lo) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end else begin
                        wr_q    <= 1'b1;
                        baddr_q <= hi_idx;
                        wdata_q <= hi_q;
                        state_q <= WR_HI;
                    end
                end
                WR_HI: begin
                    k_q    <= k_q + 15'd1;
                    addr_q <= addr_q + ADDR_W'(BYTES_PER_WORD);
                    if (last_hi) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end else begin
                        state_q   <= REQ;
                        req_vld_q <= 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;
    assign bias_ready        = ready_q;
    assign bus.rd_req_valid  = req_vld_q;
    assign bus.rd_req_addr   = addr_q;
    assign write_bias_signal = wr_q;
    assign bias_addr         = baddr_q;
    assign write_bias_data   = wdata_q;

endmodule
